// File: rtl/fs_accel_pkg.sv
// Shared definitions for the activation pipeline: function codes, bound
// selectors carried between stages, and default geometry.
package fs_accel_pkg;

  localparam int unsigned TYP_W     = 4;
  localparam int unsigned LEAK_SH_W = 4;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_FRAC_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // Activation function codes; codes 6..15 behave as pass-through.
  typedef enum logic [TYP_W-1:0] {
    ACT_RELU     = 4'd0,
    ACT_RELU6    = 4'd1,
    ACT_HSIGMOID = 4'd2,
    ACT_HTANH    = 4'd3,
    ACT_NONE     = 4'd4,
    ACT_LEAKY    = 4'd5
  } act_typ_e;

  // Lower bound: a zero floor that is not a saturation event (RELU, RELU6)
  // is kept distinct from one that is (HSIGMOID).
  typedef enum logic [1:0] {
    LO_NONE       = 2'd0,
    LO_ZERO_FLOOR = 2'd1,
    LO_ZERO_SAT   = 2'd2,
    LO_NEG_ONE    = 2'd3
  } lo_sel_e;

  typedef enum logic [1:0] {
    HI_NONE = 2'd0,
    HI_ONE  = 2'd1,
    HI_SIX  = 2'd2
  } hi_sel_e;

  typedef struct packed {
    lo_sel_e lo;
    hi_sel_e hi;
  } bnd_sel_t;

  localparam int unsigned BND_SEL_W = $bits(bnd_sel_t);

endpackage

// File: rtl/fs_accel_act_lane.sv
// One activation lane, purely combinational. The front half produces the
// pre-clamp value and bound selectors (registered in S1); the back half
// applies the clamp to the registered values and flags saturation (S2).
module fs_accel_act_lane
  import fs_accel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic [DATA_W-1:0]    x_i,
  input  logic [TYP_W-1:0]     typ_i,
  input  logic [LEAK_SH_W-1:0] leak_sh_i,
  output logic [DATA_W:0]      pre_o,
  output logic [BND_SEL_W-1:0] sel_o,
  input  logic [DATA_W:0]      pre_i,
  input  logic [BND_SEL_W-1:0] sel_i,
  output logic [DATA_W-1:0]    res_o,
  output logic                 sat_o
);

  localparam logic signed [DATA_W:0] ONE =
    {{(DATA_W-FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [DATA_W:0] SIX     = (ONE <<< 2) + (ONE <<< 1);
  localparam logic signed [DATA_W:0] HALF    = ONE >>> 1;
  localparam logic signed [DATA_W:0] NEG_ONE = -ONE;
  localparam logic signed [DATA_W:0] ZERO    = '0;

  logic signed [DATA_W:0] xs;
  logic signed [DATA_W:0] pre_s;
  logic signed [DATA_W:0] pre_r;
  logic signed [DATA_W:0] lo_val;
  logic signed [DATA_W:0] hi_val;
  bnd_sel_t               sel_a;
  bnd_sel_t               sel_b;

  // Front half: widen by one bit so the HSIGMOID offset cannot overflow.
  always_comb begin
    xs       = $signed({x_i[DATA_W-1], x_i});
    pre_s    = xs;
    sel_a.lo = LO_NONE;
    sel_a.hi = HI_NONE;
    case (typ_i)
      ACT_RELU: sel_a.lo = LO_ZERO_FLOOR;
      ACT_RELU6: begin
        sel_a.lo = LO_ZERO_FLOOR;
        sel_a.hi = HI_SIX;
      end
      ACT_HSIGMOID: begin
        pre_s    = (xs >>> 2) + HALF;
        sel_a.lo = LO_ZERO_SAT;
        sel_a.hi = HI_ONE;
      end
      ACT_HTANH: begin
        sel_a.lo = LO_NEG_ONE;
        sel_a.hi = HI_ONE;
      end
      ACT_LEAKY: if (xs[DATA_W]) pre_s = xs >>> leak_sh_i;
      default: ;
    endcase
  end

  assign pre_o = pre_s;
  assign sel_o = sel_a;

  // Back half: clamp against the selected bounds, report saturation.
  always_comb begin
    sel_b  = bnd_sel_t'(sel_i);
    pre_r  = $signed(pre_i);
    lo_val = (sel_b.lo == LO_NEG_ONE) ? NEG_ONE : ZERO;
    hi_val = (sel_b.hi == HI_SIX) ? SIX : ONE;
    res_o  = pre_i[DATA_W-1:0];
    sat_o  = 1'b0;
    if ((sel_b.lo != LO_NONE) && (pre_r < lo_val)) begin
      res_o = lo_val[DATA_W-1:0];
      sat_o = (sel_b.lo != LO_ZERO_FLOOR);
    end else if ((sel_b.hi != HI_NONE) && (pre_r > hi_val)) begin
      res_o = hi_val[DATA_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fs_accel_act_func_pipe.sv
// Two-stage multi-lane activation pipeline with valid/ready on both sides,
// idle-only configuration load and a sticky saturation event counter.
module fs_accel_act_func_pipe
  import fs_accel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [TYP_W-1:0]        cfg_typ,
  input  logic [LEAK_SH_W-1:0]    cfg_leak_sh,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        sat_cnt,
  input  logic                    cnt_clr
);

  localparam int unsigned SUM_W = $clog2(LANES + 1);

  logic [TYP_W-1:0]                    typ_q, typ_d;
  logic [LEAK_SH_W-1:0]                leak_sh_q, leak_sh_d;
  logic                                cfg_err_q, cfg_err_d;
  logic                                s1_v_q, s1_v_d;
  logic                                s2_v_q, s2_v_d;
  logic [LANES-1:0][DATA_W:0]          s1_pre_q, s1_pre_d;
  logic [LANES-1:0][BND_SEL_W-1:0]     s1_sel_q, s1_sel_d;
  logic [LANES*DATA_W-1:0]             s2_data_q, s2_data_d;
  logic [CNT_W-1:0]                    sat_cnt_q, sat_cnt_d;

  logic                                s1_en, s2_en;
  logic                                s1_load, s2_load;
  logic                                cfg_ok;
  logic [LANES-1:0][DATA_W:0]          lane_pre;
  logic [LANES-1:0][BND_SEL_W-1:0]     lane_sel;
  logic [LANES*DATA_W-1:0]             lane_res;
  logic [LANES-1:0]                    lane_sat;
  logic [SUM_W-1:0]                    sat_sum;
  logic [CNT_W:0]                      cnt_sum;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fs_accel_act_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x_i       (in_data[l*DATA_W +: DATA_W]),
      .typ_i     (typ_q),
      .leak_sh_i (leak_sh_q),
      .pre_o     (lane_pre[l]),
      .sel_o     (lane_sel[l]),
      .pre_i     (s1_pre_q[l]),
      .sel_i     (s1_sel_q[l]),
      .res_o     (lane_res[l*DATA_W +: DATA_W]),
      .sat_o     (lane_sat[l])
    );
  end

  // Handshake: an empty stage always loads, so bubbles collapse.
  always_comb begin
    s2_en   = !s2_v_q || out_ready;
    s1_en   = !s1_v_q || s2_en;
    s1_load = s1_en && in_valid;
    s2_load = s2_en && s1_v_q;
  end

  // Configuration is accepted only with the pipeline empty and no beat offered.
  always_comb begin
    cfg_ok    = cfg_we && !s1_v_q && !s2_v_q && !in_valid;
    typ_d     = cfg_ok ? cfg_typ : typ_q;
    leak_sh_d = cfg_ok ? cfg_leak_sh : leak_sh_q;
    cfg_err_d = cfg_err_q || (cfg_we && !cfg_ok);
  end

  // Stage next-state: valids follow the enables, data only on a real load.
  always_comb begin
    s1_v_d    = s1_en ? in_valid : s1_v_q;
    s2_v_d    = s2_en ? s1_v_q : s2_v_q;
    s1_pre_d  = s1_load ? lane_pre : s1_pre_q;
    s1_sel_d  = s1_load ? lane_sel : s1_sel_q;
    s2_data_d = s2_load ? lane_res : s2_data_q;
  end

  // Saturation counter: the per-lane sat bits are counted as the beat enters
  // S2; the count sticks at all-ones and a clear overrides a same-cycle add.
  always_comb begin
    sat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sat_sum = sat_sum + SUM_W'(lane_sat[i]);
    end
    cnt_sum   = {1'b0, sat_cnt_q} + {{(CNT_W+1-SUM_W){1'b0}}, sat_sum};
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr) begin
      sat_cnt_d = '0;
    end else if (s2_load) begin
      sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ_q     <= ACT_NONE;
      leak_sh_q <= '0;
      cfg_err_q <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_pre_q  <= '0;
      s1_sel_q  <= '0;
      s2_data_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      typ_q     <= typ_d;
      leak_sh_q <= leak_sh_d;
      cfg_err_q <= cfg_err_d;
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s1_pre_q  <= s1_pre_d;
      s1_sel_q  <= s1_sel_d;
      s2_data_q <= s2_data_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign in_ready  = s1_en;
  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign busy      = s1_v_q || s2_v_q;
  assign cfg_err   = cfg_err_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
